// File: rtl/cv32e40x_trigger_hit_tracker.sv
// Carries debug-trigger matches with the instruction IF->ID->EX->WB and raises a trigger debug request at WB.
// Optional per-trigger hit reporting is enabled with the CV32E40X_TRIGGER_HIT_EN macro.
module cv32e40x_trigger_hit_tracker #(
  parameter int DBG_NUM_TRIGGERS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DBG_NUM_TRIGGERS-1:0] match_if_i,
  input  logic [DBG_NUM_TRIGGERS-1:0] match_ex_i,
  input  logic                        if_valid_i,
  input  logic                        id_ready_i,
  input  logic                        id_valid_i,
  input  logic                        ex_ready_i,
  input  logic                        ex_valid_i,
  input  logic                        wb_ready_i,
  input  logic                        wb_valid_i,
  input  logic                        kill_if_i,
  input  logic                        kill_id_i,
  input  logic                        kill_ex_i,
  input  logic                        kill_wb_i,
  input  logic                        debug_ack_i,
  input  logic                        debug_mode_i,
  output logic                        debug_trigger_req_o,
  output logic                        wb_suppress_o,
  output logic [DBG_NUM_TRIGGERS-1:0] hit_set_o
);

`ifdef CV32E40X_TRIGGER_HIT_EN
  localparam int TW = DBG_NUM_TRIGGERS;
`else
  localparam int TW = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DM} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] trig_id_q, trig_id_d;
  logic [TW-1:0] trig_ex_q, trig_ex_d;
  logic [TW-1:0] trig_wb_q, trig_wb_d;
  logic [TW-1:0] match_if, match_ex;
  logic          capture_en, if_id, id_ex, ex_wb, ack_take, wb_hit;

  assign capture_en = !debug_mode_i && (state_q == IDLE);

`ifdef CV32E40X_TRIGGER_HIT_EN
  assign match_if = capture_en ? match_if_i : '0;
  assign match_ex = capture_en ? match_ex_i : '0;
`else
  assign match_if = capture_en ? (|match_if_i) : 1'b0;
  assign match_ex = capture_en ? (|match_ex_i) : 1'b0;
`endif

  assign if_id    = if_valid_i & id_ready_i;
  assign id_ex    = id_valid_i & ex_ready_i;
  assign ex_wb    = ex_valid_i & wb_ready_i;
  assign ack_take = (state_q == REQ) & debug_ack_i;
  assign wb_hit   = wb_valid_i & (|trig_wb_q);

  // An instruction leaving a killed stage carries no hits into the next one.
  always_comb begin
    trig_id_d = trig_id_q;
    if (kill_id_i || ack_take)  trig_id_d = '0;
    else if (if_id)             trig_id_d = kill_if_i ? '0 : match_if;
    else if (id_ex)             trig_id_d = '0;

    trig_ex_d = trig_ex_q;
    if (kill_ex_i || ack_take)  trig_ex_d = '0;
    else if (id_ex)             trig_ex_d = kill_id_i ? '0 : trig_id_q;
    else if (ex_valid_i)        trig_ex_d = trig_ex_q | match_ex;

    // The hitting WB entry is held on the cycle it commits to a request, and frozen until ack.
    trig_wb_d = trig_wb_q;
    if (state_q == REQ) begin
      if (debug_ack_i)          trig_wb_d = '0;
    end
    else if (kill_wb_i)         trig_wb_d = '0;
    else if (wb_hit)            trig_wb_d = trig_wb_q;
    else if (ex_wb)             trig_wb_d = kill_ex_i ? '0 : (trig_ex_q | match_ex);
    else if (!wb_valid_i)       trig_wb_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb_hit && !kill_wb_i) state_d = REQ;
      REQ:     if (debug_ack_i)          state_d = DM;
      DM:      if (!debug_mode_i)        state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      trig_id_q <= '0;
      trig_ex_q <= '0;
      trig_wb_q <= '0;
    end else begin
      state_q   <= state_d;
      trig_id_q <= trig_id_d;
      trig_ex_q <= trig_ex_d;
      trig_wb_q <= trig_wb_d;
    end
  end

  assign debug_trigger_req_o = !rst && (state_q == REQ);
  assign wb_suppress_o       = !rst && ((state_q == REQ) || ((state_q == IDLE) && wb_hit));

`ifdef CV32E40X_TRIGGER_HIT_EN
  assign hit_set_o = (!rst && ack_take) ? trig_wb_q : '0;
`else
  assign hit_set_o = '0;
`endif

endmodule
